// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared edit states, field widths and calendar helpers for rtc_calendar_core
package rtc_pkg;

  localparam int SEC_W   = 6;
  localparam int MIN_W   = 6;
  localparam int HOUR_W  = 5;
  localparam int DAY_W   = 5;
  localparam int MONTH_W = 4;
  localparam int YEAR_W  = 14;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_HOUR  = 3'd1,
    ST_MIN   = 3'd2,
    ST_DAY   = 3'd3,
    ST_MONTH = 3'd4,
    ST_YEAR  = 3'd5
  } edit_state_t;

  function automatic logic is_leap(input logic [YEAR_W-1:0] year);
    logic [31:0] y;
    y = 32'(year);
    is_leap = (y[1:0] == 2'b00) && (((y % 32'd100) != 32'd0) || ((y % 32'd400) == 32'd0));
  endfunction

  function automatic logic [DAY_W-1:0] days_in_month(input logic [MONTH_W-1:0] month,
                                                     input logic leap);
    case (month)
      4'd2:                    days_in_month = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
      default:                 days_in_month = 5'd31;
    endcase
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// rtl/btn_edge_sync.sv - 2-FF synchroniser plus rising-edge pulse for one debounced button
module btn_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_rise
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_prev;
  logic [2:0] r_warm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_warm  <= 3'b000;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_warm  <= {r_warm[1:0], 1'b1};
    end
  end

  // r_prev only holds a real sample once r_warm fills, so a button held through reset never fires
  assign o_rise = r_sync2 & ~r_prev & r_warm[2];

endmodule

// File: rtl/rtc_calendar_core.sv
// rtl/rtc_calendar_core.sv - hh:mm:ss dd/mm/yyyy clock with 1 Hz prescaler and button field editing
module rtc_calendar_core #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int YEAR_RESET = 2024,
  parameter int YEAR_MAX   = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_btn_sel,
  input  logic        i_btn_inc,
  input  logic        i_btn_dec,
  output logic [5:0]  o_sec,
  output logic [5:0]  o_min,
  output logic [4:0]  o_hour,
  output logic [4:0]  o_day,
  output logic [3:0]  o_month,
  output logic [13:0] o_year,
  output logic [2:0]  o_edit_field,
  output logic        o_leap,
  output logic        o_sec_pulse,
  output logic        o_day_pulse
);
  import rtc_pkg::*;

  localparam int                PS_W    = $clog2(CLK_HZ);
  localparam logic [PS_W-1:0]   PS_LAST = PS_W'(CLK_HZ - 1);
  localparam logic [YEAR_W-1:0] YR_MAX  = YEAR_W'(YEAR_MAX);
  localparam logic [YEAR_W-1:0] YR_RST  = YEAR_W'(YEAR_RESET);

  edit_state_t          r_state,  w_state_nxt;
  logic [PS_W-1:0]      r_presc,  w_presc_nxt;
  logic [SEC_W-1:0]     r_sec,    w_sec_nxt;
  logic [MIN_W-1:0]     r_min,    w_min_nxt;
  logic [HOUR_W-1:0]    r_hour,   w_hour_nxt;
  logic [DAY_W-1:0]     r_day,    w_day_nxt;
  logic [MONTH_W-1:0]   r_month,  w_month_nxt;
  logic [YEAR_W-1:0]    r_year,   w_year_nxt;
  logic                 r_sec_pulse, w_sec_pulse_nxt;
  logic                 r_day_pulse, w_day_pulse_nxt;

  logic                 w_sel_rise, w_inc_rise, w_dec_rise;
  logic                 w_sel, w_inc, w_dec, w_tick, w_leap;
  logic [DAY_W-1:0]     w_dim, w_clamp_dim;

  btn_edge_sync u_sync_sel (.clk(clk), .rst_n(rst_n), .i_btn(i_btn_sel), .o_rise(w_sel_rise));
  btn_edge_sync u_sync_inc (.clk(clk), .rst_n(rst_n), .i_btn(i_btn_inc), .o_rise(w_inc_rise));
  btn_edge_sync u_sync_dec (.clk(clk), .rst_n(rst_n), .i_btn(i_btn_dec), .o_rise(w_dec_rise));

  // sel wins over inc/dec; inc and dec together cancel
  assign w_sel  = w_sel_rise;
  assign w_inc  = w_inc_rise & ~w_dec_rise & ~w_sel_rise;
  assign w_dec  = w_dec_rise & ~w_inc_rise & ~w_sel_rise;
  assign w_tick = (r_presc == PS_LAST);
  assign w_leap = is_leap(r_year);
  assign w_dim  = days_in_month(r_month, w_leap);

  always_comb begin
    w_state_nxt     = r_state;
    w_presc_nxt     = '0;
    w_sec_nxt       = r_sec;
    w_min_nxt       = r_min;
    w_hour_nxt      = r_hour;
    w_day_nxt       = r_day;
    w_month_nxt     = r_month;
    w_year_nxt      = r_year;
    w_sec_pulse_nxt = 1'b0;
    w_day_pulse_nxt = 1'b0;
    w_clamp_dim     = '0;

    case (r_state)
      ST_RUN: begin
        if (w_tick) begin
          w_sec_pulse_nxt = 1'b1;
          if (r_sec == 6'd59) begin
            w_sec_nxt = '0;
            if (r_min == 6'd59) begin
              w_min_nxt = '0;
              if (r_hour == 5'd23) begin
                w_hour_nxt      = '0;
                w_day_pulse_nxt = 1'b1;
                if (r_day >= w_dim) begin
                  w_day_nxt = 5'd1;
                  if (r_month == 4'd12) begin
                    w_month_nxt = 4'd1;
                    w_year_nxt  = (r_year == YR_MAX) ? '0 : r_year + 1'b1;
                  end else begin
                    w_month_nxt = r_month + 1'b1;
                  end
                end else begin
                  w_day_nxt = r_day + 1'b1;
                end
              end else begin
                w_hour_nxt = r_hour + 1'b1;
              end
            end else begin
              w_min_nxt = r_min + 1'b1;
            end
          end else begin
            w_sec_nxt = r_sec + 1'b1;
          end
        end else begin
          w_presc_nxt = r_presc + 1'b1;
        end
        if (w_sel) begin
          w_state_nxt = ST_HOUR;
          w_presc_nxt = '0;
        end
      end
      ST_HOUR: begin
        if (w_inc)      w_hour_nxt = (r_hour == 5'd23) ? 5'd0 : r_hour + 1'b1;
        else if (w_dec) w_hour_nxt = (r_hour == 5'd0) ? 5'd23 : r_hour - 1'b1;
        if (w_sel)      w_state_nxt = ST_MIN;
      end
      ST_MIN: begin
        if (w_inc)      w_min_nxt = (r_min == 6'd59) ? 6'd0 : r_min + 1'b1;
        else if (w_dec) w_min_nxt = (r_min == 6'd0) ? 6'd59 : r_min - 1'b1;
        if (w_sel)      w_state_nxt = ST_DAY;
      end
      ST_DAY: begin
        if (w_inc)      w_day_nxt = (r_day >= w_dim) ? 5'd1 : r_day + 1'b1;
        else if (w_dec) w_day_nxt = (r_day <= 5'd1) ? w_dim : r_day - 1'b1;
        if (w_sel)      w_state_nxt = ST_MONTH;
      end
      ST_MONTH: begin
        if (w_inc)      w_month_nxt = (r_month == 4'd12) ? 4'd1 : r_month + 1'b1;
        else if (w_dec) w_month_nxt = (r_month <= 4'd1) ? 4'd12 : r_month - 1'b1;
        if (w_sel)      w_state_nxt = ST_YEAR;
      end
      ST_YEAR: begin
        if (w_inc)      w_year_nxt = (r_year >= YR_MAX) ? '0 : r_year + 1'b1;
        else if (w_dec) w_year_nxt = (r_year == '0) ? YR_MAX : r_year - 1'b1;
        if (w_sel) begin
          w_state_nxt = ST_RUN;
          w_sec_nxt   = '0;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase

    // month/year edits can shrink the month under the current day; clamp in the same update
    w_clamp_dim = days_in_month(w_month_nxt, is_leap(w_year_nxt));
    if (w_day_nxt > w_clamp_dim) w_day_nxt = w_clamp_dim;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_presc     <= '0;
      r_sec       <= '0;
      r_min       <= '0;
      r_hour      <= '0;
      r_day       <= 5'd1;
      r_month     <= 4'd1;
      r_year      <= YR_RST;
      r_sec_pulse <= 1'b0;
      r_day_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_presc     <= w_presc_nxt;
      r_sec       <= w_sec_nxt;
      r_min       <= w_min_nxt;
      r_hour      <= w_hour_nxt;
      r_day       <= w_day_nxt;
      r_month     <= w_month_nxt;
      r_year      <= w_year_nxt;
      r_sec_pulse <= w_sec_pulse_nxt;
      r_day_pulse <= w_day_pulse_nxt;
    end
  end

  assign o_sec        = r_sec;
  assign o_min        = r_min;
  assign o_hour       = r_hour;
  assign o_day        = r_day;
  assign o_month      = r_month;
  assign o_year       = r_year;
  assign o_edit_field = r_state;
  assign o_leap       = w_leap;
  assign o_sec_pulse  = r_sec_pulse;
  assign o_day_pulse  = r_day_pulse;

endmodule

// File: tb/tb_rtc_calendar_core.sv
// tb/tb_rtc_calendar_core.sv - self-checking bench for rtc_calendar_core against a calendar model
module tb_rtc_calendar_core;

  localparam int CLK_HZ     = 4;
  localparam int YEAR_RESET = 2024;
  localparam int YEAR_MAX   = 9999;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        b_sel = 1'b0, b_inc = 1'b0, b_dec = 1'b0;
  logic [5:0]  o_sec, o_min;
  logic [4:0]  o_hour, o_day;
  logic [3:0]  o_month;
  logic [13:0] o_year;
  logic [2:0]  o_edit_field;
  logic        o_leap, o_sec_pulse, o_day_pulse;
  logic [45:0] dut_vec;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rtc_calendar_core #(.CLK_HZ(CLK_HZ), .YEAR_RESET(YEAR_RESET), .YEAR_MAX(YEAR_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_btn_sel(b_sel), .i_btn_inc(b_inc), .i_btn_dec(b_dec),
    .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour), .o_day(o_day), .o_month(o_month),
    .o_year(o_year), .o_edit_field(o_edit_field), .o_leap(o_leap),
    .o_sec_pulse(o_sec_pulse), .o_day_pulse(o_day_pulse)
  );

  assign dut_vec = {o_sec, o_min, o_hour, o_day, o_month, o_year, o_edit_field,
                    o_leap, o_sec_pulse, o_day_pulse};

  // reference model: plain integer calendar, state 0=run 1..5=hour,min,day,month,year
  int m_sec, m_min, m_hour, m_day, m_month, m_year, m_state, m_cnt, m_samples;
  bit m_sp, m_dp;
  bit [2:0] h_sel, h_inc, h_dec;

  function automatic bit mleap(input int y);
    return (y % 400 == 0) || ((y % 4 == 0) && (y % 100 != 0));
  endfunction

  function automatic int mdim(input int m, input int y);
    int t[12];
    t = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    return t[m-1] + ((m == 2 && mleap(y)) ? 1 : 0);
  endfunction

  function automatic int wrap(input int v, input int step, input int lo, input int hi);
    int n;
    n = hi - lo + 1;
    return (((v - lo + step) % n) + n) % n + lo;
  endfunction

  function automatic logic [45:0] exp_vec();
    return {6'(m_sec), 6'(m_min), 5'(m_hour), 5'(m_day), 4'(m_month), 14'(m_year),
            3'(m_state), mleap(m_year), m_sp, m_dp};
  endfunction

  task automatic model_reset();
    m_sec = 0; m_min = 0; m_hour = 0; m_day = 1; m_month = 1; m_year = YEAR_RESET;
    m_state = 0; m_cnt = 0; m_samples = 0; m_sp = 0; m_dp = 0;
    h_sel = '0; h_inc = '0; h_dec = '0;
  endtask

  task automatic model_second();
    m_sp = 1;
    m_sec++;
    if (m_sec == 60) begin
      m_sec = 0; m_min++;
      if (m_min == 60) begin
        m_min = 0; m_hour++;
        if (m_hour == 24) begin
          m_hour = 0; m_dp = 1; m_day++;
          if (m_day > mdim(m_month, m_year)) begin
            m_day = 1; m_month++;
            if (m_month == 13) begin
              m_month = 1;
              m_year = (m_year + 1) % (YEAR_MAX + 1);
            end
          end
        end
      end
    end
  endtask

  task automatic model_step();
    bit armed, sel, ir, dr, inc, dec;
    int step;
    armed = (m_samples >= 3);
    sel = armed && h_sel[1] && !h_sel[2];
    ir  = armed && h_inc[1] && !h_inc[2];
    dr  = armed && h_dec[1] && !h_dec[2];
    inc = ir && !dr && !sel;
    dec = dr && !ir && !sel;
    step = inc ? 1 : (dec ? -1 : 0);
    m_sp = 0; m_dp = 0;
    if (m_state == 0) begin
      if (m_cnt == CLK_HZ - 1) begin
        m_cnt = 0;
        model_second();
      end else begin
        m_cnt++;
      end
      if (sel) begin m_state = 1; m_cnt = 0; end
    end else begin
      m_cnt = 0;
      case (m_state)
        1: m_hour  = wrap(m_hour, step, 0, 23);
        2: m_min   = wrap(m_min, step, 0, 59);
        3: m_day   = wrap(m_day, step, 1, mdim(m_month, m_year));
        4: m_month = wrap(m_month, step, 1, 12);
        default: m_year = wrap(m_year, step, 0, YEAR_MAX);
      endcase
      if (m_day > mdim(m_month, m_year)) m_day = mdim(m_month, m_year);
      if (sel) begin
        if (m_state == 5) begin m_state = 0; m_sec = 0; end
        else m_state++;
      end
    end
    h_sel = {h_sel[1:0], b_sel};
    h_inc = {h_inc[1:0], b_inc};
    h_dec = {h_dec[1:0], b_dec};
    if (m_samples < 3) m_samples++;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else model_step();
  end

  // stimulus helpers (no checking)
  task automatic set_btn(input int which, input logic v);
    case (which)
      0: b_sel = v;
      1: b_inc = v;
      default: b_dec = v;
    endcase
  endtask

  task automatic pulse(input int which, input int n);
    repeat (n) begin
      @(negedge clk); set_btn(which, 1'b1);
      @(negedge clk); set_btn(which, 1'b0);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic adjust(input int cur, input int tgt, input int lo, input int hi);
    int n, up;
    n  = hi - lo + 1;
    up = (((tgt - cur) % n) + n) % n;
    if (up <= n - up) pulse(1, up);
    else pulse(2, n - up);
  endtask

  task automatic set_time(input int h, input int mi, input int d, input int mo, input int y);
    int dim;
    for (int pass = 0; pass < 2; pass++) begin
      pulse(0, 1); adjust(m_hour, h, 0, 23);
      pulse(0, 1); adjust(m_min, mi, 0, 59);
      pulse(0, 1);
      dim = mdim(m_month, m_year);
      adjust(m_day, (d > dim) ? dim : d, 1, dim);
      pulse(0, 1); adjust(m_month, mo, 1, 12);
      pulse(0, 1); adjust(m_year, y, 0, YEAR_MAX);
      pulse(0, 1);
    end
  endtask

  task automatic run_to_midnight(output int dp_cnt, output bit reached);
    dp_cnt = 0; reached = 0;
    for (int i = 0; i < 400 && !reached; i++) begin
      @(negedge clk);
      if (o_day_pulse) dp_cnt++;
      if (m_dp) reached = 1;
    end
    repeat (2) begin
      @(negedge clk);
      if (o_day_pulse) dp_cnt++;
    end
  endtask

  // tests
  task automatic test_reset();
    logic [45:0] rst_vec;
    rst_vec = {6'd0, 6'd0, 5'd0, 5'd1, 4'd1, 14'd2024, 3'd0, 1'b1, 1'b0, 1'b0};
    rst_n = 1'b0; b_sel = 0; b_inc = 0; b_dec = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (dut_vec !== rst_vec) begin
      n_err++; $display("FAIL reset_state: got %h want %h", dut_vec, rst_vec);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (o_sec !== 6'd0) begin n_err++; $display("FAIL pre_tick_sec: got %0d want 0", o_sec); end
    @(negedge clk);
    n_vec++;
    if (o_sec !== 6'd1) begin n_err++; $display("FAIL first_tick_sec: got %0d want 1", o_sec); end
    n_vec++;
    if (o_sec_pulse !== 1'b1) begin n_err++; $display("FAIL sec_pulse_high: got %0b want 1", o_sec_pulse); end
    @(negedge clk);
    n_vec++;
    if (o_sec_pulse !== 1'b0) begin n_err++; $display("FAIL sec_pulse_low: got %0b want 0", o_sec_pulse); end
    n_vec++;
    if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL reset_model: got %h want %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_new_year();
    int dp; bit ok;
    set_time(23, 59, 31, 12, 2024);
    run_to_midnight(dp, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL new_year_timeout: got no rollover want rollover"); end
    n_vec++;
    if ({o_hour, o_min, o_sec, o_day, o_month, o_year} !== {5'd0, 6'd0, 6'd0, 5'd1, 4'd1, 14'd2025}) begin
      n_err++;
      $display("FAIL new_year_fields: got %0d:%0d:%0d %0d/%0d/%0d want 0:0:0 1/1/2025",
               o_hour, o_min, o_sec, o_day, o_month, o_year);
    end
    n_vec++;
    if (dp != 1) begin n_err++; $display("FAIL new_year_day_pulse: got %0d pulses want 1", dp); end
  endtask

  task automatic test_leap();
    int yrs[3], ed[3], em[3];
    int dp; bit ok;
    yrs = '{2024, 2100, 2000};
    ed  = '{29, 1, 29};
    em  = '{2, 3, 2};
    for (int k = 0; k < 3; k++) begin
      set_time(23, 59, 28, 2, yrs[k]);
      run_to_midnight(dp, ok);
      n_vec++;
      if (!ok || o_day !== 5'(ed[k]) || o_month !== 4'(em[k]) || o_year !== 14'(yrs[k])) begin
        n_err++;
        $display("FAIL leap_%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                 yrs[k], o_day, o_month, o_year, ed[k], em[k], yrs[k]);
      end
      n_vec++;
      if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL leap_model_%0d: got %h want %h", yrs[k], dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_clamp();
    set_time(0, 0, 31, 1, 2023);
    n_vec++;
    if ({o_day, o_month, o_year} !== {5'd31, 4'd1, 14'd2023}) begin
      n_err++; $display("FAIL clamp_preload: got %0d/%0d/%0d want 31/1/2023", o_day, o_month, o_year);
    end
    pulse(0, 4);
    n_vec++;
    if (o_edit_field !== 3'd4) begin n_err++; $display("FAIL clamp_state: got %0d want 4", o_edit_field); end
    pulse(1, 1);
    n_vec++;
    if ({o_month, o_day} !== {4'd2, 5'd28}) begin
      n_err++; $display("FAIL clamp_feb: got month %0d day %0d want month 2 day 28", o_month, o_day);
    end
    pulse(2, 1);
    pulse(2, 1);
    n_vec++;
    if ({o_month, o_day} !== {4'd12, 5'd28}) begin
      n_err++; $display("FAIL month_dec_wrap: got month %0d day %0d want month 12 day 28", o_month, o_day);
    end
    n_vec++;
    if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL clamp_model: got %h want %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_year_wrap();
    pulse(0, 1);
    n_vec++;
    if (o_edit_field !== 3'd5) begin n_err++; $display("FAIL year_state: got %0d want 5", o_edit_field); end
    adjust(m_year, YEAR_MAX, 0, YEAR_MAX);
    n_vec++;
    if (o_year !== 14'd9999) begin n_err++; $display("FAIL year_max: got %0d want 9999", o_year); end
    pulse(1, 1);
    n_vec++;
    if ({o_year, o_leap} !== {14'd0, 1'b1}) begin
      n_err++; $display("FAIL year_inc_wrap: got year %0d leap %0b want year 0 leap 1", o_year, o_leap);
    end
    pulse(2, 1);
    n_vec++;
    if ({o_year, o_leap} !== {14'd9999, 1'b0}) begin
      n_err++; $display("FAIL year_dec_wrap: got year %0d leap %0b want year 9999 leap 0", o_year, o_leap);
    end
    @(negedge clk); b_inc = 1; b_dec = 1;
    @(negedge clk); b_inc = 0; b_dec = 0;
    repeat (4) @(negedge clk);
    n_vec++;
    if ({o_year, o_edit_field} !== {14'd9999, 3'd5}) begin
      n_err++; $display("FAIL inc_dec_cancel: got year %0d state %0d want year 9999 state 5", o_year, o_edit_field);
    end
    @(negedge clk); b_sel = 1; b_inc = 1;
    @(negedge clk); b_sel = 0; b_inc = 0;
    repeat (4) @(negedge clk);
    n_vec++;
    if ({o_year, o_edit_field, o_sec} !== {14'd9999, 3'd0, 6'd0}) begin
      n_err++;
      $display("FAIL sel_beats_inc: got year %0d state %0d sec %0d want year 9999 state 0 sec 0",
               o_year, o_edit_field, o_sec);
    end
    n_vec++;
    if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL year_model: got %h want %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_reset_mid_edit();
    logic [45:0] rst_vec;
    rst_vec = {6'd0, 6'd0, 5'd0, 5'd1, 4'd1, 14'd2024, 3'd0, 1'b1, 1'b0, 1'b0};
    pulse(0, 2);
    n_vec++;
    if (o_edit_field !== 3'd2) begin n_err++; $display("FAIL mid_edit_state: got %0d want 2", o_edit_field); end
    @(negedge clk); b_inc = 1;
    @(negedge clk); rst_n = 0;
    #1;
    n_vec++;
    if (dut_vec !== rst_vec) begin n_err++; $display("FAIL async_reset: got %h want %h", dut_vec, rst_vec); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (6) @(negedge clk);
    n_vec++;
    if ({o_hour, o_min, o_day, o_month, o_year, o_edit_field} !==
        {5'd0, 6'd0, 5'd1, 4'd1, 14'd2024, 3'd0}) begin
      n_err++;
      $display("FAIL held_inc_after_reset: got %0d:%0d %0d/%0d/%0d state %0d want 0:0 1/1/2024 state 0",
               o_hour, o_min, o_day, o_month, o_year, o_edit_field);
    end
    n_vec++;
    if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL reset_edit_model: got %h want %h", dut_vec, exp_vec()); end
    b_inc = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL random_cycle_%0d: got %h want %h", i, dut_vec, exp_vec());
      end
      b_sel = ($urandom_range(0, 15) == 0);
      b_inc = ($urandom_range(0, 3) == 0);
      b_dec = ($urandom_range(0, 3) == 0);
    end
    b_sel = 0; b_inc = 0; b_dec = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_new_year();
    test_leap();
    test_clamp();
    test_year_wrap();
    test_reset_mid_edit();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
